// File: rtl/mcu_assembler_if.sv
`default_nettype none
// ============================================================================
// Module   : mcu_assembler_if
// Brief    : Sample-stream input and MCU output handshake bundle for mcu_assembler.
// Revision : 1.0 - initial release
// ============================================================================
interface mcu_assembler_if #(
    parameter int DATA_W = 32,
    parameter int DIM    = 8
);
    logic [DATA_W-1:0]                   in_data;
    logic                                in_valid;
    logic                                in_last;
    logic                                in_ready;
    logic [DIM-1:0][DIM-1:0][DATA_W-1:0] mcu_out;
    logic                                mcu_valid;
    logic                                mcu_ready;
    logic                                mcu_partial;
    logic [15:0]                         blk_count;

    modport master (
        output in_data, in_valid, in_last, mcu_ready,
        input  in_ready, mcu_out, mcu_valid, mcu_partial, blk_count
    );

    modport slave (
        input  in_data, in_valid, in_last, mcu_ready,
        output in_ready, mcu_out, mcu_valid, mcu_partial, blk_count
    );
endinterface
`default_nettype wire

// File: rtl/mcu_assembler.sv
`default_nettype none
// ============================================================================
// Module   : mcu_assembler
// Brief    : Packs a raster-ordered sample stream into DIMxDIM MCUs (row-major).
//            Define MCU_ASSEMBLER_DOUBLE_BUF_EN for ping-pong banking; single bank otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_assembler #(
    parameter int DATA_W = 32,
    parameter int DIM    = 8
) (
    input  wire            clk,
    input  wire            rst_n,
    mcu_assembler_if.slave bus
);

`ifdef MCU_ASSEMBLER_DOUBLE_BUF_EN
    localparam int c_NUM_BANKS = 2;
`else
    localparam int c_NUM_BANKS = 1;
`endif
    // Row/column are bit fields of the index, so DIM must be a power of two.
    localparam int c_RC_W     = $clog2(DIM);
    localparam int c_IDX_W    = 2 * c_RC_W;
    localparam int c_LAST_IDX = DIM * DIM - 1;

    typedef enum logic [0:0] {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    typedef logic [DIM-1:0][DIM-1:0][DATA_W-1:0] mcu_t;

    bank_state_t        r_state [c_NUM_BANKS];
    mcu_t               r_data  [c_NUM_BANKS];
    logic               r_part  [c_NUM_BANKS];
    logic [c_IDX_W-1:0] r_idx;
    logic [15:0]        r_blk_count;

    logic               w_fill_sel;
    logic               w_out_sel;
    logic               w_in_ready;
    logic               w_mcu_valid;
    logic               w_accept;
    logic               w_close;
    logic               w_short;
    logic               w_out_hs;
    logic [c_RC_W-1:0]  w_row;
    logic [c_RC_W-1:0]  w_col;

`ifdef MCU_ASSEMBLER_DOUBLE_BUF_EN
    logic r_fill_sel;
    logic r_out_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_sel <= 1'b0;
            r_out_sel  <= 1'b0;
        end else begin
            if (w_accept && w_close) begin
                r_fill_sel <= ~r_fill_sel;
            end
            if (w_out_hs) begin
                r_out_sel <= ~r_out_sel;
            end
        end
    end

    assign w_fill_sel      = r_fill_sel;
    assign w_out_sel       = r_out_sel;
    assign w_in_ready      = (r_state[w_fill_sel] != BANK_FULL);
    assign w_mcu_valid     = (r_state[w_out_sel] == BANK_FULL);
    assign bus.mcu_out     = r_data[w_out_sel];
    assign bus.mcu_partial = r_part[w_out_sel];
`else
    assign w_fill_sel      = 1'b0;
    assign w_out_sel       = 1'b0;
    assign w_in_ready      = (r_state[0] != BANK_FULL);
    assign w_mcu_valid     = (r_state[0] == BANK_FULL);
    assign bus.mcu_out     = r_data[0];
    assign bus.mcu_partial = r_part[0];
`endif

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_out_hs = w_mcu_valid && bus.mcu_ready;
    assign w_close  = (r_idx == c_IDX_W'(c_LAST_IDX)) || bus.in_last;
    assign w_short  = bus.in_last && (r_idx != c_IDX_W'(c_LAST_IDX));
    assign w_row    = r_idx[c_IDX_W-1:c_RC_W];
    assign w_col    = r_idx[c_RC_W-1:0];

    // A released bank is cleared so that a short block reads zero past its last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < c_NUM_BANKS; b++) begin
                r_state[b] <= BANK_EMPTY;
                r_data[b]  <= '0;
                r_part[b]  <= 1'b0;
            end
        end else begin
            for (int b = 0; b < c_NUM_BANKS; b++) begin
                if (w_out_hs && (int'(w_out_sel) == b)) begin
                    r_state[b] <= BANK_EMPTY;
                    r_data[b]  <= '0;
                    r_part[b]  <= 1'b0;
                end else if (w_accept && (int'(w_fill_sel) == b)) begin
                    r_data[b][w_row][w_col] <= bus.in_data;
                    if (w_close) begin
                        r_state[b] <= BANK_FULL;
                        r_part[b]  <= w_short;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_blk_count <= '0;
        end else begin
            if (w_accept) begin
                r_idx <= w_close ? '0 : r_idx + 1'b1;
            end
            if (w_out_hs) begin
                r_blk_count <= r_blk_count + 16'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mcu_valid = w_mcu_valid;
    assign bus.blk_count = r_blk_count;

endmodule
`default_nettype wire
